// File: rtl/fp_rsqrt_iter.sv
// fp_rsqrt_iter: sequential IEEE-754 double inverse square root, y ~= 1/sqrt(x).
//
// The unit seeds y with the integer bit-trick estimate MAGIC - (x >> 1). It then runs
// ITERS Newton-Raphson steps, y <- y * (1.5 - 0.5*x*y*y). One multiplier and one adder
// are shared across all cycles.
//
// Optional feature macro: FP_RSQRT_SQRT_MODE_EN. When it is defined, the sqrt_mode input
// is added. A latched sqrt_mode=1 adds a final x*y step, so the unit returns sqrt(x).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand valid
//   in_ready   unit can accept (high only while idle)
//   x_in       operand, IEEE-754 double
//   sqrt_mode  (FP_RSQRT_SQRT_MODE_EN only) return sqrt(x) instead of 1/sqrt(x)
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   y_out      result, IEEE-754 double
//   special    result came from the special-case path (qualified by out_valid)
//
// Arithmetic flushes subnormal operands and results to zero and rounds to nearest-even.
`timescale 1ns/1ps
module fp_rsqrt_iter #(
    parameter int unsigned ITERS = 2,
    parameter logic [63:0] MAGIC = 64'h5FE6EB50C7B537A9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] x_in,
`ifdef FP_RSQRT_SQRT_MODE_EN
    input  logic        sqrt_mode,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] y_out,
    output logic        special
);

    generate
        if ((ITERS == 0) || (ITERS > 4)) begin : g_bad_iters
            $error("fp_rsqrt_iter: ITERS must be in 1..4");
        end
    endgenerate

    localparam logic [63:0] N2      = 64'h3FE0000000000000;  // 0.5
    localparam logic [63:0] THREE_2 = 64'h3FF8000000000000;  // 1.5
    localparam logic [63:0] QNAN    = 64'h7FF8000000000000;
    localparam logic [63:0] POS_INF = 64'h7FF0000000000000;
    localparam logic [63:0] NEG_INF = 64'hFFF0000000000000;
    localparam logic [2:0]  LAST_K  = 3'(ITERS - 1);

`ifdef FP_RSQRT_SQRT_MODE_EN
    typedef enum logic [2:0] {StIdle, StSeed, StSq, StMx, StSub, StMy, StDone, StMxy} state_t;
`else
    typedef enum logic [2:0] {StIdle, StSeed, StSq, StMx, StSub, StMy, StDone} state_t;
`endif

    // Multiply; subnormal inputs and underflowing results become signed zero.
    function automatic logic [63:0] fp_mul(input logic [63:0] a, input logic [63:0] b);
        logic               sign;
        logic [105:0]       p;
        logic [52:0]        m;
        logic               g;
        logic               st;
        logic [53:0]        mr;
        logic signed [12:0] e;
        sign = a[63] ^ b[63];
        if ((a[62:52] == 11'd0) || (b[62:52] == 11'd0)) return {sign, 63'd0};
        p = 106'({1'b1, a[51:0]}) * 106'({1'b1, b[51:0]});
        e = $signed({2'b00, a[62:52]}) + $signed({2'b00, b[62:52]}) - 13'sd1023;
        if (p[105]) begin
            m  = p[105:53];
            g  = p[52];
            st = |p[51:0];
            e  = e + 13'sd1;
        end else begin
            m  = p[104:52];
            g  = p[51];
            st = |p[50:0];
        end
        mr = {1'b0, m} + 54'(g & (st | m[0]));
        if (mr[53]) begin
            mr = mr >> 1;
            e  = e + 13'sd1;
        end
        if (e <= 13'sd0) return {sign, 63'd0};
        if (e >= 13'sd2047) return {sign, 11'h7FF, 52'd0};
        return {sign, e[10:0], mr[51:0]};
    endfunction

    // Add with guard/round/sticky alignment; subnormals flush to zero.
    function automatic logic [63:0] fp_add(input logic [63:0] a, input logic [63:0] b);
        logic [63:0]        hi;
        logic [63:0]        lo;
        logic [10:0]        d;
        logic [55:0]        mh;
        logic [55:0]        ml;
        logic [55:0]        ms;
        logic [56:0]        sum;
        logic [55:0]        m;
        logic [53:0]        mr;
        logic signed [12:0] e;
        logic               found;
        int                 lz;
        if (a[62:0] >= b[62:0]) begin
            hi = a;
            lo = b;
        end else begin
            hi = b;
            lo = a;
        end
        if (hi[62:52] == 11'd0) return 64'd0;
        if (lo[62:52] == 11'd0) return hi;
        mh = {1'b1, hi[51:0], 3'b000};
        ml = {1'b1, lo[51:0], 3'b000};
        d  = hi[62:52] - lo[62:52];
        ms = ml >> d;
        if ((ms << d) != ml) ms[0] = 1'b1;  // sticky: bits lost in alignment
        e = $signed({2'b00, hi[62:52]});
        if (hi[63] == lo[63]) begin
            sum = {1'b0, mh} + {1'b0, ms};
            if (sum[56]) begin
                m    = sum[56:1];
                m[0] = m[0] | sum[0];
                e    = e + 13'sd1;
            end else begin
                m = sum[55:0];
            end
        end else begin
            m = mh - ms;
            if (m == 56'd0) return 64'd0;
            lz    = 0;
            found = 1'b0;
            for (int i = 55; i >= 0; i--) begin
                if (!found) begin
                    if (m[i]) found = 1'b1;
                    else lz++;
                end
            end
            m = m << lz;
            e = e - 13'(lz);
        end
        mr = {1'b0, m[55:3]} + 54'(m[2] & (m[1] | m[0] | m[3]));
        if (mr[53]) begin
            mr = mr >> 1;
            e  = e + 13'sd1;
        end
        if (e <= 13'sd0) return {hi[63], 63'd0};
        if (e >= 13'sd2047) return {hi[63], 11'h7FF, 52'd0};
        return {hi[63], e[10:0], mr[51:0]};
    endfunction

    state_t      state_q;
    logic [63:0] x_q;
    logic [63:0] xh_q;
    logic [63:0] y_q;
    logic [63:0] t_q;
    logic [2:0]  k_q;
    logic        sqrt_q;

    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_y;
    logic [63:0] add_y;
    logic        spec_hit;
    logic [63:0] spec_val;

`ifndef FP_RSQRT_SQRT_MODE_EN
    assign sqrt_q = 1'b0;
`endif

    // Shared multiplier operand selection.
    always_comb begin
        mul_a = y_q;
        mul_b = y_q;
        case (state_q)
            StSeed: begin
                mul_a = x_q;
                mul_b = N2;
            end
            StMx: begin
                mul_a = t_q;
                mul_b = xh_q;
            end
            StMy: begin
                mul_a = y_q;
                mul_b = t_q;
            end
`ifdef FP_RSQRT_SQRT_MODE_EN
            StMxy: begin
                mul_a = x_q;
                mul_b = y_q;
            end
`endif
            default: begin
                mul_a = y_q;
                mul_b = y_q;
            end
        endcase
    end

    assign mul_y = fp_mul(mul_a, mul_b);
    assign add_y = fp_add(THREE_2, {~t_q[63], t_q[62:0]});

    // Special-case classification; subnormals are treated as zero of the same sign.
    always_comb begin
        spec_hit = 1'b1;
        spec_val = 64'd0;
        if ((x_q[62:52] == 11'h7FF) && (x_q[51:0] != 52'd0)) begin
            spec_val = QNAN;
        end else if (x_q[62:52] == 11'd0) begin
            if (sqrt_q) spec_val = {x_q[63], 63'd0};
            else        spec_val = x_q[63] ? NEG_INF : POS_INF;
        end else if (x_q[63]) begin
            spec_val = QNAN;
        end else if (x_q[62:52] == 11'h7FF) begin
            spec_val = sqrt_q ? POS_INF : 64'd0;
        end else begin
            spec_hit = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            y_out     <= 64'd0;
            special   <= 1'b0;
            x_q       <= 64'd0;
            xh_q      <= 64'd0;
            y_q       <= 64'd0;
            t_q       <= 64'd0;
            k_q       <= 3'd0;
`ifdef FP_RSQRT_SQRT_MODE_EN
            sqrt_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        x_q      <= x_in;
`ifdef FP_RSQRT_SQRT_MODE_EN
                        sqrt_q   <= sqrt_mode;
`endif
                        in_ready <= 1'b0;
                        state_q  <= StSeed;
                    end
                end
                StSeed: begin
                    if (spec_hit) begin
                        y_out     <= spec_val;
                        special   <= 1'b1;
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        y_q     <= MAGIC - (x_q >> 1);
                        xh_q    <= mul_y;
                        k_q     <= 3'd0;
                        state_q <= StSq;
                    end
                end
                StSq: begin
                    t_q     <= mul_y;
                    state_q <= StMx;
                end
                StMx: begin
                    t_q     <= mul_y;
                    state_q <= StSub;
                end
                StSub: begin
                    t_q     <= add_y;
                    state_q <= StMy;
                end
                StMy: begin
                    y_q <= mul_y;
                    k_q <= k_q + 3'd1;
                    if (k_q == LAST_K) begin
`ifdef FP_RSQRT_SQRT_MODE_EN
                        if (sqrt_q) begin
                            state_q <= StMxy;
                        end else begin
`else
                        begin
`endif
                            y_out     <= mul_y;
                            special   <= 1'b0;
                            out_valid <= 1'b1;
                            state_q   <= StDone;
                        end
                    end else begin
                        state_q <= StSq;
                    end
                end
`ifdef FP_RSQRT_SQRT_MODE_EN
                StMxy: begin
                    y_out     <= mul_y;
                    special   <= 1'b0;
                    out_valid <= 1'b1;
                    state_q   <= StDone;
                end
`endif
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
